tempsense_ctrl: RTL and testbench
=================================

Name: tempsense_ctrl

Overview:
Measurement sequencer for the tempsenseInst macro behind the TL-UL temperature-sensor adapter. It replaces direct software poking of RESET/SEL_CONV_TIME/en. On a one-shot or periodic trigger it resets the sensor counter, enables conversion, and waits for a synchronised DONE with a timeout. It then captures DOUT, applies a threshold compare, and presents the result to the register interface.

Parameters:
RstCycles, 4, cycles sensor RESET_COUNTERn held low per measurement (>=1)
SettleCycles, 2, cycles between reset release and en assertion (>=1)
TimeoutW, 20, width of conversion-timeout counter
PeriodW, 24, width of periodic-interval counter
DoutW, 24, sensor DOUT width

Ports:
clk_i  in  1  system clock
rst_ni  in  1  async active-low reset
start_i  in  1  one-cycle one-shot trigger (register write)
periodic_en_i  in  1  level; enables free-running periodic measurement
period_i  in  PeriodW  cycles from CAPTURE to next measurement start
conv_time_i  in  4  SEL_CONV_TIME value, latched at measurement start
timeout_i  in  TimeoutW  max cycles in CONVERT; 0 disables timeout
thresh_hi_i  in  DoutW  alert threshold
abort_i  in  1  one-cycle abort; returns to IDLE
sens_rstn_o  out  1  to RESET_COUNTERn
sens_sel_o  out  4  to SEL_CONV_TIME
sens_en_o  out  1  to en
sens_done_i  in  1  sensor DONE, asynchronous, 2-flop synchronised internally
sens_dout_i  in  DoutW  sensor DOUT, stable while DONE high
busy_o  out  1  FSM not in IDLE/WAIT
result_o  out  DoutW  last captured (or averaged) value
result_valid_o  out  1  one-cycle pulse on new result
timeout_o  out  1  sticky timeout flag, cleared by next start
alert_o  out  1  level; last result > thresh_hi_i

Behaviour:
- Reset: FSM=IDLE, sens_rstn_o=0, sens_en_o=0, sens_sel_o=0, result_o=0, result_valid_o=0, timeout_o=0, alert_o=0, busy_o=0, all counters 0.
- IDLE: start_i, or periodic_en_i rising, -> RESET. Latch conv_time_i into sens_sel_o. Clear timeout_o.
- RESET: sens_rstn_o=0 for exactly RstCycles cycles -> SETTLE.
- SETTLE: sens_rstn_o=1, sens_en_o=0 for SettleCycles -> CONVERT.
- CONVERT: sens_en_o=1.
  - Rising edge of synchronised DONE (done_s & ~done_q) -> CAPTURE.
  - If timeout_i!=0 and cycle count reaches timeout_i first -> timeout_o=1, sens_en_o=0, -> IDLE (no result_valid).
  - DONE edge and timeout in the same cycle: DONE wins.
- CAPTURE (1 cycle): result_o<=sens_dout_i; result_valid_o=1 next cycle; alert_o<=(sens_dout_i>thresh_hi_i), unsigned compare; sens_en_o=0. Then -> WAIT if periodic_en_i, else IDLE.
- WAIT: count period_i cycles, then -> RESET. period_i=0 means restart the next cycle. periodic_en_i low -> IDLE immediately.
- start_i while busy: ignored. start_i in WAIT: -> RESET immediately.
- abort_i in any state: -> IDLE, sens_en_o=0, sens_rstn_o=0, no result.
- DONE already high at CONVERT entry is not an edge; a fresh rising edge is required.
- Latency, start_i to result_valid_o with DONE seen at cycle k of CONVERT: RstCycles+SettleCycles+k+2 sync cycles+2.
- Sensor outputs are registered (glitch-free toward the analog macro).

Optional Feature:
TEMPSENSE_CTRL_AVG_EN
- Defined: each trigger performs 4 back-to-back conversions (RESET->SETTLE->CONVERT->CAPTURE loop, WAIT skipped between them).
  - Accumulator is DoutW+2 bits.
  - result_o=acc>>2 (truncate); one result_valid_o after the 4th sample.
  - A timeout on any sample aborts the burst.
  - alert_o uses the averaged value.
- Undefined: single conversion per trigger; no accumulator logic.

Decomposition:
- Package tempsense_ctrl_pkg holds:
  - FSM state enum: IDLE, RESET, SETTLE, CONVERT, CAPTURE, WAIT, 3-bit.
  - Default constants for RstCycles and SettleCycles.
- One sub-module: tempsense_done_sync, a 2-flop synchroniser plus edge detector (reset 0).
- Counters stay inline.

Test Plan:
- Reset, then start_i; sensor model raises DONE 10 cycles into CONVERT with DOUT=24'h00ABCD -> sens_rstn_o low 4 cycles, en high, result_o=24'h00ABCD, result_valid_o pulses once, busy_o drops.
- timeout_i=50, DONE never rises -> timeout_o=1 at CONVERT cycle 50, sens_en_o=0, no result_valid_o; next start_i clears timeout_o.
- periodic_en_i=1, period_i=100 -> three results, CAPTURE-to-next-RESET spacing 100 cycles; deassert periodic_en_i in WAIT -> IDLE.
- thresh_hi_i=24'h001000: DOUT=24'h001000 gives alert_o=0; DOUT=24'h001001 gives alert_o=1.
- abort_i mid-CONVERT -> IDLE next cycle, en=0, no result; start_i while busy is ignored.
- With TEMPSENSE_CTRL_AVG_EN, DOUT samples 100,101,102,104 -> result_o=101, exactly one valid pulse.

Source files
------------

// File: rtl/tempsense_ctrl_pkg.sv
// Shared types and defaults for the temperature-sensor measurement sequencer.
package tempsense_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StReset   = 3'd1,
    StSettle  = 3'd2,
    StConvert = 3'd3,
    StCapture = 3'd4,
    StWait    = 3'd5
  } state_e;

  localparam int unsigned DefRstCycles    = 4;
  localparam int unsigned DefSettleCycles = 2;

endpackage

// File: rtl/tempsense_done_sync.sv
// Two-flop synchroniser for the asynchronous sensor DONE plus a rising-edge detector.
module tempsense_done_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic done_i,
  output logic rise_o
);

  logic [1:0] sync_q;
  logic       done_q;

  // Synchronise DONE and keep one delayed copy for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
      done_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], done_i};
      done_q <= sync_q[1];
    end
  end

  assign rise_o = sync_q[1] & ~done_q;

endmodule

// File: rtl/tempsense_ctrl.sv
// Measurement sequencer for the tempsenseInst macro: reset, settle, convert, capture, compare.
// Build option TEMPSENSE_CTRL_AVG_EN: average four back-to-back conversions per trigger.
module tempsense_ctrl
  import tempsense_ctrl_pkg::*;
#(
  parameter int unsigned RstCycles    = DefRstCycles,
  parameter int unsigned SettleCycles = DefSettleCycles,
  parameter int unsigned TimeoutW     = 20,
  parameter int unsigned PeriodW      = 24,
  parameter int unsigned DoutW        = 24
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                periodic_en_i,
  input  logic [PeriodW-1:0]  period_i,
  input  logic [3:0]          conv_time_i,
  input  logic [TimeoutW-1:0] timeout_i,
  input  logic [DoutW-1:0]    thresh_hi_i,
  input  logic                abort_i,
  output logic                sens_rstn_o,
  output logic [3:0]          sens_sel_o,
  output logic                sens_en_o,
  input  logic                sens_done_i,
  input  logic [DoutW-1:0]    sens_dout_i,
  output logic                busy_o,
  output logic [DoutW-1:0]    result_o,
  output logic                result_valid_o,
  output logic                timeout_o,
  output logic                alert_o
);

  // One counter serves the reset/settle phases, the conversion timeout and the periodic wait.
  localparam int unsigned CntW = (TimeoutW > PeriodW) ? TimeoutW : PeriodW;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              periodic_q;
  logic              done_rise;
  logic              periodic_rise;
  logic              timeout_hit;
  logic              wait_done;
  logic [TimeoutW:0] conv_next;
  logic [PeriodW:0]  wait_next;
  logic [DoutW-1:0]  sample;
  logic              last_sample;

  tempsense_done_sync u_done_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .done_i (sens_done_i),
    .rise_o (done_rise)
  );

  assign periodic_rise = periodic_en_i & ~periodic_q;
  assign conv_next     = {1'b0, cnt_q[TimeoutW-1:0]} + {{TimeoutW{1'b0}}, 1'b1};
  assign timeout_hit   = (timeout_i != '0) && (conv_next == {1'b0, timeout_i});
  // WAIT spans period_i cycles, minimum one, so period_i of 0 restarts on the next cycle.
  assign wait_next     = {1'b0, cnt_q[PeriodW-1:0]} + {{PeriodW{1'b0}}, 1'b1};
  assign wait_done     = (wait_next >= {1'b0, period_i});
  assign busy_o        = (state_q != StIdle) && (state_q != StWait);

`ifdef TEMPSENSE_CTRL_AVG_EN
  logic [1:0]       avg_cnt_q;
  logic [DoutW+1:0] acc_q;
  logic [DoutW+1:0] acc_sum;

  assign acc_sum     = acc_q + {2'b00, sens_dout_i};
  assign sample      = acc_sum[DoutW+1:2];
  assign last_sample = (avg_cnt_q == 2'd3);

  // Burst accumulator: cleared on every new trigger, summed at each capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      avg_cnt_q <= 2'd0;
      acc_q     <= '0;
    end else if ((state_q == StIdle) || (state_q == StWait)) begin
      avg_cnt_q <= 2'd0;
      acc_q     <= '0;
    end else if ((state_q == StCapture) && !abort_i) begin
      avg_cnt_q <= avg_cnt_q + 2'd1;
      acc_q     <= acc_sum;
    end
  end
`else
  assign sample      = sens_dout_i;
  assign last_sample = 1'b1;
`endif

  // Sequencer FSM; sensor-facing outputs are registered alongside the state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      periodic_q     <= 1'b0;
      sens_rstn_o    <= 1'b0;
      sens_sel_o     <= 4'd0;
      sens_en_o      <= 1'b0;
      result_o       <= '0;
      result_valid_o <= 1'b0;
      timeout_o      <= 1'b0;
      alert_o        <= 1'b0;
    end else begin
      periodic_q     <= periodic_en_i;
      result_valid_o <= 1'b0;
      if (abort_i) begin
        state_q     <= StIdle;
        cnt_q       <= '0;
        sens_en_o   <= 1'b0;
        sens_rstn_o <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_i || periodic_rise) begin
              state_q     <= StReset;
              cnt_q       <= '0;
              sens_sel_o  <= conv_time_i;
              timeout_o   <= 1'b0;
              sens_rstn_o <= 1'b0;
              sens_en_o   <= 1'b0;
            end
          end
          StReset: begin
            if (cnt_q == CntW'(RstCycles - 1)) begin
              state_q     <= StSettle;
              cnt_q       <= '0;
              sens_rstn_o <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StSettle: begin
            if (cnt_q == CntW'(SettleCycles - 1)) begin
              state_q   <= StConvert;
              cnt_q     <= '0;
              sens_en_o <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StConvert: begin
            // A DONE edge takes priority over a timeout landing in the same cycle.
            if (done_rise) begin
              state_q   <= StCapture;
              cnt_q     <= '0;
              sens_en_o <= 1'b0;
            end else if (timeout_hit) begin
              state_q     <= StIdle;
              cnt_q       <= '0;
              timeout_o   <= 1'b1;
              sens_en_o   <= 1'b0;
              sens_rstn_o <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StCapture: begin
            cnt_q <= '0;
            if (last_sample) begin
              result_o       <= sample;
              result_valid_o <= 1'b1;
              alert_o        <= (sample > thresh_hi_i);
              if (periodic_en_i) begin
                state_q <= StWait;
              end else begin
                state_q     <= StIdle;
                sens_rstn_o <= 1'b0;
              end
            end else begin
              // Next sample of an averaging burst goes straight back to RESET.
              state_q     <= StReset;
              sens_rstn_o <= 1'b0;
            end
          end
          StWait: begin
            if (!periodic_en_i) begin
              state_q     <= StIdle;
              cnt_q       <= '0;
              sens_rstn_o <= 1'b0;
            end else if (start_i || wait_done) begin
              state_q     <= StReset;
              cnt_q       <= '0;
              sens_sel_o  <= conv_time_i;
              timeout_o   <= 1'b0;
              sens_rstn_o <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            sens_en_o   <= 1'b0;
            sens_rstn_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tempsense_ctrl.sv
// Bench for tempsense_ctrl: sensor model plus reference expectations from the behaviour rules.
module tb_tempsense_ctrl;

  localparam int unsigned RstC = 4;
  localparam int unsigned SetC = 2;
  localparam int unsigned TW   = 20;
  localparam int unsigned PW   = 24;
  localparam int unsigned DW   = 24;
`ifdef TEMPSENSE_CTRL_AVG_EN
  localparam int NS = 4;
`else
  localparam int NS = 1;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic          periodic_en_i;
  logic [PW-1:0] period_i;
  logic [3:0]    conv_time_i;
  logic [TW-1:0] timeout_i;
  logic [DW-1:0] thresh_hi_i;
  logic          abort_i;
  logic          sens_rstn_o;
  logic [3:0]    sens_sel_o;
  logic          sens_en_o;
  logic          sens_done_i;
  logic [DW-1:0] sens_dout_i;
  logic          busy_o;
  logic [DW-1:0] result_o;
  logic          result_valid_o;
  logic          timeout_o;
  logic          alert_o;

  tempsense_ctrl dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .periodic_en_i  (periodic_en_i),
    .period_i       (period_i),
    .conv_time_i    (conv_time_i),
    .timeout_i      (timeout_i),
    .thresh_hi_i    (thresh_hi_i),
    .abort_i        (abort_i),
    .sens_rstn_o    (sens_rstn_o),
    .sens_sel_o     (sens_sel_o),
    .sens_en_o      (sens_en_o),
    .sens_done_i    (sens_done_i),
    .sens_dout_i    (sens_dout_i),
    .busy_o         (busy_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .timeout_o      (timeout_o),
    .alert_o        (alert_o)
  );

  always #5 clk_i = ~clk_i;

  int compared   = 0;
  int mismatched = 0;

  // Observation counters and sensor-model state, all owned by the main process.
  int            valid_cnt    = 0;
  int            rst_low_cnt  = 0;
  int            settle_cnt   = 0;
  int            en_high_cnt  = 0;
  int            low_run      = 0;
  int            last_low_run = 0;
  bit            en_seen      = 1'b0;
  int            en_cyc       = 0;
  int            conv_idx     = 0;
  int            done_delay   = 10;
  bit            done_never   = 1'b0;
  logic [DW-1:0] dout_tab [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, then update the sensor model's drive.
  task tick();
    @(negedge clk_i);
    if (result_valid_o) valid_cnt++;
    if (!sens_rstn_o) en_seen = 1'b0;
    if (busy_o && !sens_rstn_o) rst_low_cnt++;
    if (busy_o && sens_rstn_o && !sens_en_o && !en_seen) settle_cnt++;
    if (sens_en_o) begin
      en_seen = 1'b1;
      en_high_cnt++;
    end
    if (!busy_o) low_run++;
    else begin
      if (low_run != 0) last_low_run = low_run;
      low_run = 0;
    end
    if (sens_en_o) begin
      en_cyc++;
      if (!done_never && (en_cyc == done_delay) && !sens_done_i) begin
        sens_done_i = 1'b1;
        sens_dout_i = dout_tab[conv_idx % 8];
        conv_idx++;
      end
    end else begin
      en_cyc      = 0;
      sens_done_i = 1'b0;
    end
  endtask

  task pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic start_and_wait(input int budget, output int ok);
    ok = 0;
    pulse_start();
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy_o) begin
        ok = 1;
        break;
      end
    end
  endtask

  // Load the next burst's DOUT values; returns the value the controller should report.
  task automatic load(input logic [DW-1:0] v0, input logic [DW-1:0] v1,
                      input logic [DW-1:0] v2, input logic [DW-1:0] v3,
                      output logic [DW-1:0] expv);
    longint sum;
    dout_tab[(conv_idx + 0) % 8] = v0;
    dout_tab[(conv_idx + 1) % 8] = v1;
    dout_tab[(conv_idx + 2) % 8] = v2;
    dout_tab[(conv_idx + 3) % 8] = v3;
    if (NS == 4) begin
      sum  = longint'(v0) + longint'(v1) + longint'(v2) + longint'(v3);
      expv = DW'(sum / 4);
    end else begin
      expv = v0;
    end
  endtask

  initial begin
    int            ok;
    int            v_base;
    int            r_base;
    int            s_base;
    int            e_base;
    logic [DW-1:0] expv;
    logic [DW-1:0] d0, d1, d2, d3;
    logic [3:0]    ct;

    rst_ni        = 1'b0;
    start_i       = 1'b0;
    periodic_en_i = 1'b0;
    period_i      = '0;
    conv_time_i   = 4'd0;
    timeout_i     = '0;
    thresh_hi_i   = '0;
    abort_i       = 1'b0;
    sens_done_i   = 1'b0;
    sens_dout_i   = '0;
    for (int i = 0; i < 8; i++) dout_tab[i] = '0;

    repeat (3) tick();
    check("rst_sens_rstn", 32'(sens_rstn_o), 0);
    check("rst_sens_en", 32'(sens_en_o), 0);
    check("rst_sens_sel", 32'(sens_sel_o), 0);
    check("rst_result", 32'(result_o), 0);
    check("rst_valid", 32'(result_valid_o), 0);
    check("rst_timeout", 32'(timeout_o), 0);
    check("rst_alert", 32'(alert_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    rst_ni = 1'b1;
    repeat (2) tick();

    // Basic one-shot measurement.
    thresh_hi_i = 24'h100000;
    conv_time_i = 4'h5;
    done_delay  = 10;
    load(24'h00ABCD, 24'h00ABCD, 24'h00ABCD, 24'h00ABCD, expv);
    v_base = valid_cnt; r_base = rst_low_cnt; s_base = settle_cnt; e_base = en_high_cnt;
    start_and_wait(200 * NS, ok);
    tick();
    check("basic_done", ok, 1);
    check("basic_result", 32'(result_o), 32'(expv));
    check("basic_valid_once", valid_cnt - v_base, 1);
    check("basic_rst_low", rst_low_cnt - r_base, RstC * NS);
    check("basic_settle", settle_cnt - s_base, SetC * NS);
    check("basic_en_high", en_high_cnt - e_base, (10 + 2) * NS);
    check("basic_sel", 32'(sens_sel_o), 5);
    check("basic_alert", 32'(alert_o), 0);
    check("basic_en_off", 32'(sens_en_o), 0);

    // Randomised one-shot measurements.
    for (int it = 0; it < 6; it++) begin
      d0 = DW'($urandom); d1 = DW'($urandom); d2 = DW'($urandom); d3 = DW'($urandom);
      ct = 4'($urandom_range(0, 15));
      load(d0, d1, d2, d3, expv);
      thresh_hi_i = (it % 2 == 0) ? DW'($urandom) : expv - DW'(it);
      conv_time_i = ct;
      done_delay  = $urandom_range(1, 20);
      v_base = valid_cnt;
      start_and_wait(200 * NS, ok);
      tick();
      check("rand_done", ok, 1);
      check("rand_result", 32'(result_o), 32'(expv));
      check("rand_alert", 32'(alert_o), 32'(expv > thresh_hi_i));
      check("rand_valid_once", valid_cnt - v_base, 1);
      check("rand_sel", 32'(sens_sel_o), 32'(ct));
    end

    // Threshold boundary: equal is not an alert, one above is.
    thresh_hi_i = 24'h001000;
    done_delay  = 7;
    load(24'h001000, 24'h001000, 24'h001000, 24'h001000, expv);
    start_and_wait(200 * NS, ok);
    tick();
    check("thr_eq_result", 32'(result_o), 32'h001000);
    check("thr_eq_alert", 32'(alert_o), 0);
    load(24'h001001, 24'h001001, 24'h001001, 24'h001001, expv);
    start_and_wait(200 * NS, ok);
    tick();
    check("thr_gt_result", 32'(result_o), 32'h001001);
    check("thr_gt_alert", 32'(alert_o), 1);

    // Averaging pattern (single-sample build reports the first value).
    load(24'd100, 24'd101, 24'd102, 24'd104, expv);
    v_base = valid_cnt;
    start_and_wait(200 * NS, ok);
    tick();
    check("avg_result", 32'(result_o), (NS == 4) ? 101 : 100);
    check("avg_valid_once", valid_cnt - v_base, 1);

    // Conversion timeout with DONE never rising.
    timeout_i  = 20'd50;
    done_never = 1'b1;
    v_base = valid_cnt; e_base = en_high_cnt;
    start_and_wait(400, ok);
    tick();
    check("to_done", ok, 1);
    check("to_flag", 32'(timeout_o), 1);
    check("to_en_cycles", en_high_cnt - e_base, 50);
    check("to_no_valid", valid_cnt - v_base, 0);
    check("to_en_off", 32'(sens_en_o), 0);
    done_never = 1'b0;
    done_delay = 5;
    load(24'h000321, 24'h000321, 24'h000321, 24'h000321, expv);
    v_base = valid_cnt;
    pulse_start();
    check("to_cleared_by_start", 32'(timeout_o), 0);
    ok = 0;
    for (int i = 0; i < 200 * NS; i++) begin
      tick();
      if (!busy_o) begin
        ok = 1;
        break;
      end
    end
    tick();
    check("to_recover_done", ok, 1);
    check("to_recover_valid", valid_cnt - v_base, 1);

    // DONE edge landing in the timeout cycle wins; one cycle later it loses.
    done_delay = 48;
    load(24'h000777, 24'h000777, 24'h000777, 24'h000777, expv);
    v_base = valid_cnt;
    start_and_wait(400 * NS, ok);
    tick();
    check("tie_valid", valid_cnt - v_base, 1);
    check("tie_no_timeout", 32'(timeout_o), 0);
    check("tie_result", 32'(result_o), 32'h000777);
    done_delay = 49;
    v_base = valid_cnt;
    start_and_wait(400, ok);
    tick();
    check("late_timeout", 32'(timeout_o), 1);
    check("late_no_valid", valid_cnt - v_base, 0);
    timeout_i = '0;

    // Periodic mode: three results, 100-cycle wait between them, then disable in WAIT.
    for (int i = 0; i < 8; i++) dout_tab[i] = 24'h0055AA;
    done_delay    = 8;
    period_i      = 24'd100;
    v_base        = valid_cnt;
    periodic_en_i = 1'b1;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (valid_cnt - v_base == 3) begin
        ok = 1;
        break;
      end
    end
    check("per_three_results", ok, 1);
    check("per_wait_len", last_low_run, 100);
    check("per_result", 32'(result_o), 32'h0055AA);
    repeat (10) tick();
    check("per_in_wait", 32'(busy_o), 0);
    periodic_en_i = 1'b0;
    r_base = rst_low_cnt;
    repeat (200) tick();
    check("per_stopped_valid", valid_cnt - v_base, 3);
    check("per_stopped_rst", rst_low_cnt - r_base, 0);
    check("per_stopped_busy", 32'(busy_o), 0);

    // Abort mid-conversion.
    done_delay = 1000;
    v_base = valid_cnt;
    pulse_start();
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (sens_en_o) begin
        ok = 1;
        break;
      end
    end
    check("abort_reached_convert", ok, 1);
    repeat (3) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_busy", 32'(busy_o), 0);
    check("abort_en", 32'(sens_en_o), 0);
    check("abort_rstn", 32'(sens_rstn_o), 0);
    repeat (30) tick();
    check("abort_no_valid", valid_cnt - v_base, 0);

    // start_i while busy must not restart the sequence.
    done_delay = 6;
    load(24'h000ABC, 24'h000ABC, 24'h000ABC, 24'h000ABC, expv);
    v_base = valid_cnt; r_base = rst_low_cnt;
    pulse_start();
    tick();
    pulse_start();
    ok = 0;
    for (int i = 0; i < 200 * NS; i++) begin
      tick();
      if (!busy_o) begin
        ok = 1;
        break;
      end
    end
    tick();
    check("busy_start_done", ok, 1);
    check("busy_start_rst_low", rst_low_cnt - r_base, RstC * NS);
    check("busy_start_valid", valid_cnt - v_base, 1);
    check("busy_start_result", 32'(result_o), 32'(expv));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
